// File: rtl/bcd_to_bin_seq.sv
// Digit-serial packed-BCD to binary converter, most significant digit first.
// Each conversion computes acc = acc*10 + digit and flags any digit above 9.
`timescale 1ns/1ps
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_bin,
    output logic                  out_err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [BIN_W-1:0]      acc_q, acc_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]      bin_q, bin_d;
    logic                  oerr_q, oerr_d;

    logic [3:0]            cur_digit;
    logic [BIN_W-1:0]      acc_next;
    logic                  err_next;
    logic                  last_digit;

    // Mux-based digit select keeps the index width independent of DIGITS.
    function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] word,
                                            input logic [CNT_W-1:0]    idx);
        logic [3:0] d;
        d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == CNT_W'(i)) begin
                d = word[4*i +: 4];
            end
        end
        return d;
    endfunction

    // Multiply by ten as two shifts and an add; the result wraps mod 2^BIN_W.
    function automatic logic [BIN_W-1:0] mul10_add(input logic [BIN_W-1:0] acc,
                                                   input logic [3:0]       d);
        return (acc << 3) + (acc << 1) + BIN_W'(d);
    endfunction

    assign cur_digit  = digit_at(bcd_q, cnt_q);
    assign acc_next   = mul10_add(acc_q, cur_digit);
    assign err_next   = err_q | (cur_digit > 4'd9);
    assign last_digit = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            oerr_q  <= oerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)   state_d = S_CONV;
            S_CONV: if (last_digit) state_d = S_DONE;
            S_DONE: if (out_ready)  state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Datapath next-state; the result registers load only on the final digit.
    always_comb begin
        acc_d  = acc_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        bcd_d  = bcd_q;
        bin_d  = bin_q;
        oerr_d = oerr_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bcd_d = in_bcd;
                    acc_d = '0;
                    err_d = 1'b0;
                    cnt_d = CNT_W'(DIGITS - 1);
                end
            end
            S_CONV: begin
                acc_d = acc_next;
                err_d = err_next;
                if (last_digit) begin
                    bin_d  = acc_next;
                    oerr_d = err_next;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        out_bin   = bin_q;
        out_err   = oerr_q;
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed plus randomized bench for bcd_to_bin_seq against a positional-value
// reference model (sum of digit * 10^position, wrapped to BIN_W bits).
`timescale 1ns/1ps
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] in_bcd;
    logic                out_valid;
    logic                out_ready;
    logic [BIN_W-1:0]    out_bin;
    logic                out_err;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_bin(input logic [4*DIGITS-1:0] w);
        longint v;
        longint p;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            v = v + longint'(w[4*i +: 4]) * p;
            p = p * 10;
        end
        return int'(v % (longint'(1) << BIN_W));
    endfunction

    function automatic logic model_err(input logic [4*DIGITS-1:0] w);
        logic e;
        e = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w[4*i +: 4] > 4'd9) e = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction with `hold` cycles of backpressure in DONE.
    task automatic conv(input logic [4*DIGITS-1:0] w, input int hold, input string tag);
        int n;
        int lat;
        int exp_bin;
        logic exp_err;
        exp_bin = model_bin(w);
        exp_err = model_err(w);
        in_bcd    = w;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, ".ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_bcd   = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, DIGITS);
        check({tag, ".bin"}, out_bin, exp_bin);
        check({tag, ".err"}, out_err, exp_err);
        check({tag, ".busy"}, in_ready, 0);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_bcd   = 16'($urandom);
            tick();
            check({tag, ".hold_valid"}, out_valid, 1);
            check({tag, ".hold_bin"}, out_bin, exp_bin);
            check({tag, ".hold_err"}, out_err, exp_err);
            check({tag, ".hold_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".drop_valid"}, out_valid, 0);
        check({tag, ".idle_ready"}, in_ready, 1);
        check({tag, ".bin_kept"}, out_bin, exp_bin);
    endtask

    initial begin
        logic [4*DIGITS-1:0] stream [3];
        int acc_edge [3];
        int idx;
        int results;
        int edge_n;
        logic acc_now;
        logic hs;
        logic [BIN_W-1:0] b;
        logic [4*DIGITS-1:0] w;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b0;
        #2;
        check("reset.in_ready", in_ready, 1);
        check("reset.out_valid", out_valid, 0);
        check("reset.out_bin", out_bin, 0);
        check("reset.out_err", out_err, 0);
        #5;
        rst_n = 1'b1;
        tick();

        conv(16'h9999, 0, "t1_9999");
        conv(16'h0000, 0, "t2_0000");
        conv(16'h0001, 0, "t2_0001");
        conv(16'h12A4, 0, "t3_12A4");
        conv(16'h0042, 5, "t4_0042");

        // Reset two edges after accepting a word.
        in_bcd   = 16'h5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.out_valid", out_valid, 0);
        check("t5.out_bin", out_bin, 0);
        check("t5.out_err", out_err, 0);
        check("t5.in_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        tick();
        conv(16'h0100, 0, "t5_0100");

        // Streaming with in_valid held high and no backpressure.
        stream[0] = 16'h0007;
        stream[1] = 16'h1234;
        stream[2] = 16'h9000;
        idx = 0;
        results = 0;
        edge_n = 0;
        in_bcd    = stream[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (results < 3 && edge_n < 200) begin
            acc_now = in_valid && in_ready;
            hs      = out_valid && out_ready;
            b       = out_bin;
            tick();
            edge_n++;
            if (acc_now) begin
                acc_edge[idx] = edge_n;
                idx++;
                if (idx < 3) in_bcd = stream[idx];
                else         in_valid = 1'b0;
            end
            if (hs) begin
                check("t6.bin", b, model_bin(stream[results]));
                results++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t6.results", results, 3);
        check("t6.accepts", idx, 3);
        check("t6.gap01", acc_edge[1] - acc_edge[0], DIGITS + 2);
        check("t6.gap12", acc_edge[2] - acc_edge[1], DIGITS + 2);
        tick();

        // Randomized words, with invalid digits mixed in, and random backpressure.
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < DIGITS; i++) begin
                if ($urandom_range(0, 3) == 0) w[4*i +: 4] = 4'($urandom_range(10, 15));
                else                           w[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            conv(w, $urandom_range(0, 3), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
